// File: rtl/clk_defs_pkg.sv
// Shared clock-setting definitions: write addresses,
// field limits and the set-controller state encoding.
package clk_defs;

    localparam logic [1:0] ADDR_SEC  = 2'b00;
    localparam logic [1:0] ADDR_MIN  = 2'b01;

    localparam int unsigned FIELD_W   = 6;
    localparam int unsigned FIELD_MAX = 59;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_EDIT_MIN   = 3'd1,
        ST_COMMIT_MIN = 3'd2,
        ST_EDIT_SEC   = 3'd3,
        ST_COMMIT_SEC = 3'd4
    } set_state_e;

    // Values read from the counters above the field limit
    // are treated as garbage and start the edit at zero.
    function automatic logic [FIELD_W-1:0] clamp_field(
        input logic [FIELD_W-1:0] v,
        input logic [FIELD_W-1:0] max_v
    );
        return (v > max_v) ? '0 : v;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_btn_edge.sv
// Registered rising-edge detector for one debounced button.
// A button held through reset yields no edge.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic rise_o
);

    logic btn_q;
    logic rise_q;

    // Track the previous level and register the rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q  <= btn_i;
            rise_q <= 1'b0;
        end else begin
            btn_q  <= btn_i;
            rise_q <= btn_i & ~btn_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Button-driven time-setting controller: edits minutes then
// seconds and issues one write strobe per committed field.
module clock_set_ctrl
    import clk_defs::*;
#(
    parameter int unsigned MAX_VAL        = FIELD_MAX,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
    parameter int unsigned CNT_W          = 29
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_mode,
    input  logic               btn_inc,
    input  logic               btn_dec,
    input  logic [FIELD_W-1:0] seconds_in,
    input  logic [FIELD_W-1:0] minutes_in,
    output logic               load,
    output logic [1:0]         addrs,
    output logic [FIELD_W-1:0] data_out,
    output logic               edit_active,
    output logic               edit_field,
    output logic [FIELD_W-1:0] edit_value
);

    localparam logic [FIELD_W-1:0] MAX_V = FIELD_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic mode_e;
    logic inc_e;
    logic dec_e;

    btn_edge u_mode (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_mode),
        .rise_o (mode_e)
    );

    btn_edge u_inc (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_inc),
        .rise_o (inc_e)
    );

    btn_edge u_dec (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_dec),
        .rise_o (dec_e)
    );

    set_state_e         state_q, state_d;
    logic [FIELD_W-1:0] value_q, value_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               load_q, load_d;
    logic [1:0]         addrs_q, addrs_d;
    logic [FIELD_W-1:0] data_q, data_d;
    logic               active_q, active_d;
    logic               field_q, field_d;

    logic [FIELD_W-1:0] inc_val;
    logic [FIELD_W-1:0] dec_val;

    assign inc_val = (value_q == MAX_V) ? '0 : value_q + 1'b1;
    assign dec_val = (value_q == '0) ? MAX_V : value_q - 1'b1;

    // Next state, edited value and idle timeout.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (mode_e) begin
                    state_d = ST_EDIT_MIN;
                    value_d = clamp_field(minutes_in, MAX_V);
                    cnt_d   = '0;
                end
            end
            ST_EDIT_MIN, ST_EDIT_SEC: begin
                if (mode_e) begin
                    state_d = (state_q == ST_EDIT_MIN) ?
                              ST_COMMIT_MIN : ST_COMMIT_SEC;
                    cnt_d   = '0;
                end else if (inc_e || dec_e) begin
                    cnt_d = '0;
                    if (inc_e && !dec_e) begin
                        value_d = inc_val;
                    end else if (dec_e && !inc_e) begin
                        value_d = dec_val;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_COMMIT_MIN: begin
                state_d = ST_EDIT_SEC;
                value_d = clamp_field(seconds_in, MAX_V);
                cnt_d   = '0;
            end
            ST_COMMIT_SEC: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output values for the coming state, so every port is a flop.
    always_comb begin
        load_d   = (state_d == ST_COMMIT_MIN) ||
                   (state_d == ST_COMMIT_SEC);
        addrs_d  = (state_d == ST_COMMIT_MIN) ? ADDR_MIN : ADDR_SEC;
        data_d   = load_d ? value_d : '0;
        active_d = (state_d == ST_EDIT_MIN) ||
                   (state_d == ST_EDIT_SEC);
        field_d  = (state_d == ST_EDIT_SEC) ||
                   (state_d == ST_COMMIT_SEC);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            value_q  <= '0;
            cnt_q    <= '0;
            load_q   <= 1'b0;
            addrs_q  <= ADDR_SEC;
            data_q   <= '0;
            active_q <= 1'b0;
            field_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            cnt_q    <= cnt_d;
            load_q   <= load_d;
            addrs_q  <= addrs_d;
            data_q   <= data_d;
            active_q <= active_d;
            field_q  <= field_d;
        end
    end

    assign load        = load_q;
    assign addrs       = addrs_q;
    assign data_out    = data_q;
    assign edit_active = active_q;
    assign edit_field  = field_q;
    assign edit_value  = value_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: vector table,
// write scoreboard and hand-written timeout/reset sequences.
module tb_clock_set_ctrl;

    logic       clk;
    logic       reset;
    logic       btn_mode, btn_inc, btn_dec;
    logic       b2_mode, b2_inc, b2_dec;
    logic [5:0] min_in, sec_in;

    logic       load, load2;
    logic [1:0] addrs, addrs2;
    logic [5:0] data_out, data2;
    logic       edit_active, active2;
    logic       edit_field, field2;
    logic [5:0] edit_value, value2;

    clock_set_ctrl #(
        .MAX_VAL        (59),
        .TIMEOUT_CYCLES (100),
        .CNT_W          (7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_mode    (btn_mode),
        .btn_inc     (btn_inc),
        .btn_dec     (btn_dec),
        .seconds_in  (sec_in),
        .minutes_in  (min_in),
        .load        (load),
        .addrs       (addrs),
        .data_out    (data_out),
        .edit_active (edit_active),
        .edit_field  (edit_field),
        .edit_value  (edit_value)
    );

    clock_set_ctrl #(
        .MAX_VAL        (23),
        .TIMEOUT_CYCLES (100),
        .CNT_W          (7)
    ) dut2 (
        .clk         (clk),
        .reset       (reset),
        .btn_mode    (b2_mode),
        .btn_inc     (b2_inc),
        .btn_dec     (b2_dec),
        .seconds_in  (sec_in),
        .minutes_in  (min_in),
        .load        (load2),
        .addrs       (addrs2),
        .data_out    (data2),
        .edit_active (active2),
        .edit_field  (field2),
        .edit_value  (value2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         m, i, d;
        logic [5:0] mi, si;
        bit         wr;
        logic [1:0] wa;
        logic [5:0] wd;
        logic [5:0] ev;
        bit         ea, ef;
    } vec_t;

    typedef struct {
        logic [1:0] a;
        logic [5:0] d;
    } wr_t;

    vec_t vecs[$];
    wr_t  exp_q[$];

    int   tests = 0;
    int   fails = 0;
    bit   prev_load = 1'b0;
    int   n_load2 = 0;
    logic [1:0] last2_a = 2'b11;
    logic [5:0] last2_d = 6'h3f;

    function automatic vec_t mk(
        input bit m, input bit i, input bit d,
        input int mi, input int si,
        input bit wr, input int wa, input int wd,
        input int ev, input bit ea, input bit ef
    );
        vec_t v;
        v.m = m; v.i = i; v.d = d;
        v.mi = 6'(mi); v.si = 6'(si);
        v.wr = wr; v.wa = 2'(wa); v.wd = 6'(wd);
        v.ev = 6'(ev); v.ea = ea; v.ef = ef;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one cycle and score any write strobe from dut.
    task automatic tick();
        wr_t w;
        @(posedge clk);
        #1;
        if (load2) begin
            n_load2++;
            last2_a = addrs2;
            last2_d = data2;
        end
        if (load) begin
            chk("load_single_cycle", int'(prev_load), 0);
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_load: addrs=%0d data=%0d",
                         addrs, data_out);
            end else begin
                w = exp_q.pop_front();
                if (addrs !== w.a || data_out !== w.d) begin
                    fails++;
                    $display("FAIL write: got a=%0d d=%0d expected a=%0d d=%0d",
                             addrs, data_out, w.a, w.d);
                end
            end
        end
        prev_load = load;
    endtask

    task automatic press(input bit m, input bit i, input bit d);
        btn_mode = m; btn_inc = i; btn_dec = d;
        tick();
        btn_mode = 0; btn_inc = 0; btn_dec = 0;
        tick();
        tick();
    endtask

    task automatic press2(input bit m, input bit i, input bit d);
        b2_mode = m; b2_inc = i; b2_dec = d;
        tick();
        b2_mode = 0; b2_inc = 0; b2_dec = 0;
        tick();
        tick();
    endtask

    task automatic push_wr(input logic [1:0] a, input logic [5:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    // Count cycles spent in an edit state, optionally with one inc.
    task automatic run_timeout(input int inc_at, output int n);
        n = 0;
        for (int s = 0; s < 400; s++) begin
            if (!edit_active) break;
            n++;
            if (s == inc_at) btn_inc = 1;
            if (s == inc_at + 2) btn_inc = 0;
            tick();
        end
        btn_inc = 0;
    endtask

    int n_act;

    initial begin
        reset = 1; min_in = 12; sec_in = 34;
        btn_mode = 0; btn_inc = 0; btn_dec = 0;
        b2_mode = 0; b2_inc = 0; b2_dec = 0;

        vecs.push_back(mk(1,0,0, 12,34, 0,0,0,  12,1,0));
        vecs.push_back(mk(0,1,0, 12,34, 0,0,0,  13,1,0));
        vecs.push_back(mk(0,1,0, 12,34, 0,0,0,  14,1,0));
        vecs.push_back(mk(0,1,0, 12,34, 0,0,0,  15,1,0));
        vecs.push_back(mk(1,0,0, 12,34, 1,1,15, 34,1,1));
        vecs.push_back(mk(0,0,1, 12,34, 0,0,0,  33,1,1));
        vecs.push_back(mk(1,0,0, 12,34, 1,0,33, 33,0,0));
        vecs.push_back(mk(1,0,0, 59,0,  0,0,0,  59,1,0));
        vecs.push_back(mk(0,1,0, 59,0,  0,0,0,  0,1,0));
        vecs.push_back(mk(0,0,1, 59,0,  0,0,0,  59,1,0));
        vecs.push_back(mk(0,0,1, 59,0,  0,0,0,  58,1,0));
        vecs.push_back(mk(0,1,1, 59,0,  0,0,0,  58,1,0));
        vecs.push_back(mk(1,1,0, 59,0,  1,1,58, 0,1,1));
        vecs.push_back(mk(0,0,1, 59,0,  0,0,0,  59,1,1));
        vecs.push_back(mk(0,1,0, 59,0,  0,0,0,  0,1,1));
        vecs.push_back(mk(1,0,0, 59,0,  1,0,0,  0,0,0));
        vecs.push_back(mk(1,0,0, 62,63, 0,0,0,  0,1,0));
        vecs.push_back(mk(0,1,0, 62,63, 0,0,0,  1,1,0));
        vecs.push_back(mk(1,0,0, 62,63, 1,1,1,  0,1,1));
        vecs.push_back(mk(1,0,0, 62,63, 1,0,0,  0,0,0));
        vecs.push_back(mk(0,1,0, 62,63, 0,0,0,  0,0,0));
        vecs.push_back(mk(0,0,1, 62,63, 0,0,0,  0,0,0));

        tick(); tick(); tick();
        reset = 0;
        tick();
        chk("rst_load", int'(load), 0);
        chk("rst_addrs", int'(addrs), 0);
        chk("rst_data", int'(data_out), 0);
        chk("rst_active", int'(edit_active), 0);
        chk("rst_field", int'(edit_field), 0);
        chk("rst_value", int'(edit_value), 0);

        foreach (vecs[k]) begin
            min_in = vecs[k].mi;
            sec_in = vecs[k].si;
            if (vecs[k].wr) push_wr(vecs[k].wa, vecs[k].wd);
            press(vecs[k].m, vecs[k].i, vecs[k].d);
            chk($sformatf("vec%0d_value", k), int'(edit_value), int'(vecs[k].ev));
            chk($sformatf("vec%0d_active", k), int'(edit_active), int'(vecs[k].ea));
            chk($sformatf("vec%0d_field", k), int'(edit_field), int'(vecs[k].ef));
        end

        min_in = 23; sec_in = 30;
        press2(1,0,0);
        chk("max23_entry", int'(value2), 23);
        press2(0,1,0);
        chk("max23_inc_wrap", int'(value2), 0);
        press2(0,0,1);
        chk("max23_dec_wrap", int'(value2), 23);
        press2(0,0,1);
        press2(1,0,0);
        chk("max23_sec_clamp", int'(value2), 0);
        chk("max23_field", int'(field2), 1);
        press2(1,0,0);
        chk("max23_idle", int'(active2), 0);
        chk("max23_writes", n_load2, 2);
        chk("max23_last_addr", int'(last2_a), 0);
        chk("max23_last_data", int'(last2_d), 0);

        min_in = 5; sec_in = 7;
        btn_mode = 1; tick(); btn_mode = 0; tick();
        chk("to_entry", int'(edit_active), 1);
        run_timeout(-10, n_act);
        chk("to_cycles", n_act, 100);
        chk("to_value", int'(edit_value), 5);

        btn_mode = 1; tick(); btn_mode = 0; tick();
        run_timeout(88, n_act);
        chk("to_inc_cycles", n_act, 190);
        chk("to_inc_value", int'(edit_value), 6);

        btn_inc = 1;
        for (int c = 0; c < 1000; c++) tick();
        btn_inc = 0;
        tick(); tick();
        chk("idle_hold_active", int'(edit_active), 0);
        chk("idle_hold_value", int'(edit_value), 6);

        min_in = 40;
        press(1,0,0);
        chk("hold_entry", int'(edit_value), 40);
        btn_inc = 1;
        for (int c = 0; c < 50; c++) tick();
        btn_inc = 0;
        tick(); tick();
        chk("hold_one_step", int'(edit_value), 41);
        push_wr(2'b01, 6'd41);
        press(1,0,0);
        chk("hold_sec_entry", int'(edit_value), 7);
        push_wr(2'b00, 6'd7);
        press(1,0,0);
        chk("hold_exit", int'(edit_active), 0);

        min_in = 10;
        press(1,0,0);
        chk("rc_entry", int'(edit_value), 10);
        push_wr(2'b01, 6'd10);
        btn_mode = 1; tick(); btn_mode = 0; tick();
        chk("rc_in_commit", int'(load), 1);
        reset = 1; btn_mode = 1;
        tick();
        chk("rc_load", int'(load), 0);
        chk("rc_addrs", int'(addrs), 0);
        chk("rc_data", int'(data_out), 0);
        chk("rc_active", int'(edit_active), 0);
        chk("rc_field", int'(edit_field), 0);
        chk("rc_value", int'(edit_value), 0);
        tick(); tick();
        reset = 0;
        for (int c = 0; c < 5; c++) tick();
        chk("held_mode_no_entry", int'(edit_active), 0);
        btn_mode = 0;
        for (int c = 0; c < 3; c++) tick();
        chk("held_mode_released", int'(edit_active), 0);

        chk("writes_pending", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Button-driven time-setting controller that drives the clock's load/address/data write interface. It is the initiator for the `load`/`addrs`/`data_in` port of the seconds and minutes counters. It sits beside the timekeeping core and is fed by the debounced mode/inc/dec buttons. It reads back the live `seconds_out`/`minutes_out`, lets the user edit minutes and then seconds, and issues one single-cycle write per field.

## Interface
- `MAX_VAL`, 59: highest field value; inc/dec wrap within 0..MAX_VAL.
- `TIMEOUT_CYCLES`, 500_000_000: idle cycles in an edit state before the edit is abandoned (10 s at 50 MHz).
- `CNT_W`, 29: timeout counter width; must satisfy 2^CNT_W ≥ TIMEOUT_CYCLES.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `btn_mode`  in  1  debounced level; a rising edge advances the edit sequence.
- `btn_inc`  in  1  debounced level; a rising edge increments the edited field.
- `btn_dec`  in  1  debounced level; a rising edge decrements the edited field.
- `seconds_in`  in  6  live seconds value from the counter.
- `minutes_in`  in  6  live minutes value from the counter.
- `load`  out  1  write strobe, one cycle per commit.
- `addrs`  out  2  write target: ADDR_SEC or ADDR_MIN.
- `data_out`  out  6  write data, valid when `load`=1.
- `edit_active`  out  1  high in EDIT_MIN/EDIT_SEC.
- `edit_field`  out  1  0 = minutes, 1 = seconds (display blink select).
- `edit_value`  out  6  value currently being edited.

## Operation
- Edge detection: each button is registered once. Edge = btn & ~btn_q.
- FSM states: IDLE, EDIT_MIN, COMMIT_MIN, EDIT_SEC, COMMIT_SEC.
- IDLE:
  - mode edge → EDIT_MIN; `edit_value` ← `minutes_in`.
  - inc/dec edges ignored.
- EDIT_MIN / EDIT_SEC:
  - inc edge: `edit_value` = (v==MAX_VAL) ? 0 : v+1.
  - dec edge: `edit_value` = (v==0) ? MAX_VAL : v-1.
  - inc and dec in the same cycle: no change, but the timeout counter still restarts.
  - mode edge (has priority over inc/dec in the same cycle): EDIT_MIN → COMMIT_MIN; EDIT_SEC → COMMIT_SEC.
  - timeout expiry → IDLE with no write.
- COMMIT_MIN (1 cycle): `load`=1, `addrs`=ADDR_MIN, `data_out`=`edit_value`. Next state EDIT_SEC; `edit_value` ← `seconds_in` sampled in this cycle.
- COMMIT_SEC (1 cycle): `load`=1, `addrs`=ADDR_SEC, `data_out`=`edit_value`. Next state IDLE.
- Button edges arriving in commit states are dropped.
- Outside commit states: `load`=0, `addrs`=ADDR_SEC, `data_out`=0.
- Timeout counter:
  - Cleared on entry to an edit state and on any accepted inc/dec/mode edge.
  - Increments each cycle while in an edit state.
  - Counter reaching TIMEOUT_CYCLES-1 forces IDLE on the next edge of `clk`.
- Out-of-range `*_in` (>MAX_VAL) captured at edit entry is clamped to 0.

## Timing
- Reset values: state IDLE, `load`=0, `addrs`=ADDR_SEC, `data_out`=0, `edit_active`=0, `edit_field`=0, `edit_value`=0, timeout counter 0. Button edge registers load the current button levels, so a button already held during reset produces no edge.
- Button latency: a level first sampled high at edge N changes state/outputs after edge N+1. All outputs are registered.
- `load` is exactly one cycle wide. Writes are never back-to-back: at least one EDIT_SEC cycle separates the minutes write from the seconds write.
- Reset asserted mid-operation, including during a commit cycle: `load` is 0 in the cycle after the reset edge and no pending write completes.
- A held button generates one edge only. There is no auto-repeat.

## Structure
- Shared package/include `clk_defs`: ADDR_SEC=2'b00, ADDR_MIN=2'b01, field MAX value 59, FSM state encodings. The counters use the same address constants.
- One natural sub-module: `btn_edge`, a per-button registered rising-edge detector with synchronous reset, instantiated three times.
- Wrap-around inc/dec arithmetic and the FSM stay in `clock_set_ctrl`.

## Test plan
- Reset, minutes_in=12, seconds_in=34: mode → edit_value=12; inc×3 → 15; mode → one `load` cycle with addrs=01, data_out=15; edit_value=34. dec → 33; mode → `load` with addrs=00, data_out=33; then IDLE.
- Wrap: edit_value=59, inc → 0. edit_value=0, dec → 59. With MAX_VAL=23 (parameter override), 23 inc → 0.
- Simultaneous events: inc+dec in the same cycle → value unchanged. mode+inc in the same cycle → commit of the un-incremented value.
- Timeout with TIMEOUT_CYCLES=100: enter EDIT_MIN, no buttons for 100 cycles → IDLE, `load` never asserted. A single inc at cycle 90 postpones the exit to cycle 190.
- Reset during COMMIT_MIN → `load`=0 the next cycle, all outputs at reset values. btn_mode held high through reset release → no edit entry.
- inc/dec in IDLE and a held button for 1000 cycles → exactly zero or one action, and no `load`.
